// File: rtl/uart_rx_monitor.sv
// 8N1 serial receiver that watches the SoC uart_tx line and reports decoded bytes.
// Runs in the SoC clock domain; independent of the SoC's own UART.
module uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy,
    output logic [7:0] o_byte_count
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e           r_state, w_state_d;
    logic             r_sync0, r_sync1;
    logic             w_rx_s;
    logic [CNT_W-1:0] r_timer, w_timer_d;
    logic [2:0]       r_bit_idx, w_bit_idx_d;
    logic [7:0]       r_shift, w_shift_d;
    logic [7:0]       r_data, w_data_d;
    logic [7:0]       r_byte_count, w_byte_count_d;
    logic             r_valid, w_valid_d;
    logic             r_frame_err, w_frame_err_d;

    assign w_rx_s = r_sync1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync0      <= 1'b1;
            r_sync1      <= 1'b1;
            r_state      <= StIdle;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_byte_count <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync0      <= i_rx;
            r_sync1      <= r_sync0;
            r_state      <= w_state_d;
            r_timer      <= w_timer_d;
            r_bit_idx    <= w_bit_idx_d;
            r_shift      <= w_shift_d;
            r_data       <= w_data_d;
            r_byte_count <= w_byte_count_d;
            r_valid      <= w_valid_d;
            r_frame_err  <= w_frame_err_d;
        end
    end

    // Every timed state clears the timer on entry; its event fires at timer == N-1.
    always_comb begin
        w_state_d      = r_state;
        w_timer_d      = r_timer + CNT_W'(1);
        w_bit_idx_d    = r_bit_idx;
        w_shift_d      = r_shift;
        w_data_d       = r_data;
        w_byte_count_d = r_byte_count;
        w_valid_d      = 1'b0;
        w_frame_err_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_timer_d = '0;
                if (!w_rx_s) w_state_d = StStart;
            end
            StStart: begin
                if (r_timer == HALF_LAST) begin
                    w_timer_d = '0;
                    if (!w_rx_s) begin
                        w_state_d   = StData;
                        w_bit_idx_d = '0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_d   = '0;
                    w_shift_d   = {w_rx_s, r_shift[7:1]};
                    w_bit_idx_d = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_d = StStop;
                end
            end
            StStop: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_d = '0;
                    if (w_rx_s) begin
                        w_data_d       = r_shift;
                        w_valid_d      = 1'b1;
                        w_byte_count_d = r_byte_count + 8'd1;
                        w_state_d      = StIdle;
                    end else begin
                        w_frame_err_d = 1'b1;
                        w_state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // A held-low line must return high before a new start bit is accepted.
                w_timer_d = '0;
                if (w_rx_s) w_state_d = StIdle;
            end
            default: begin
                w_timer_d = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_state != StIdle);
    assign o_byte_count = r_byte_count;

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Board-level serial receiver that listens on the line driven by the SoC's uart_tx pin and decodes 8N1 frames into bytes. It lets the board top show SoC console traffic on LEDs, or feed it to a logic-analyser tap, without involving the host.
It runs in the 10 MHz SoC clock domain and is fully independent of the SoC's internal UART.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit; 10 MHz / 115200 baud; legal range 4 to 65535.
HALF_BIT, CLKS_PER_BIT/2 (integer divide), cycles from the start-bit falling edge to the start-bit mid-sample; derived, not overridden.
CNT_W, $clog2(CLKS_PER_BIT), width of the bit timer; derived.

Ports:
clock  input  1  system clock (10 MHz on marsohod3).
reset  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line; idles high.
data  output  8  last correctly received byte; held until the next good frame.
valid  output  1  one-cycle pulse; data updated in the same cycle.
frame_err  output  1  one-cycle pulse when the stop bit samples 0.
busy  output  1  high in every state except IDLE.
byte_count  output  8  number of good frames received, wraps 255 -> 0.

Behaviour:
- Input synchronisation
  - rx passes through 2 flops (sync0, sync1); rx_s = sync1.
  - Both flops reset to 1.
- Reset
  - Takes effect on the clock edge, overrides any state.
  - state = IDLE; timer = 0; bit index = 0; shift register = 0.
  - data = 0, valid = 0, frame_err = 0, busy = 0, byte_count = 0.
- Timer rule: on entry to a timed state, timer = 0. The state's event fires in the cycle where timer == N-1, so each timed state lasts N cycles.
- FSM states
  - IDLE: when rx_s == 0, go to START.
  - START, N = HALF_BIT: at the event, if rx_s == 0 go to DATA with bit index = 0; otherwise go to IDLE (glitch rejected, no outputs).
  - DATA, N = CLKS_PER_BIT, repeated per bit: at each event, shift rx_s in LSB-first (shift = {rx_s, shift[7:1]}). After bit index 7, go to STOP.
  - STOP, N = CLKS_PER_BIT, at the event:
    - rx_s == 1: data <= shift, valid <= 1, byte_count <= byte_count + 1; go to IDLE.
    - rx_s == 0: frame_err <= 1, data unchanged; go to BREAK.
  - BREAK: wait until rx_s == 1, then go to IDLE. A line held low does not re-trigger START.
- Outputs
  - valid and frame_err are registered, high for exactly 1 cycle, and never high together.
- Latency
  - Count from the first cycle IDLE sees rx_s == 0.
  - valid asserts exactly 1 + HALF_BIT + 9*CLKS_PER_BIT cycles later.
  - Add 2 cycles of synchroniser delay from the rx pin.
- Back-to-back frames: the IDLE re-entry cycle is enough to catch a start bit that immediately follows the stop bit. No inter-frame gap is required.
- Sampling: each bit is sampled at its nominal centre. The receiver tolerates ±4% baud mismatch at CLKS_PER_BIT ≥ 16.
- busy rises in the cycle after IDLE detects the low level and falls on IDLE re-entry.

Test Plan:
- CLKS_PER_BIT = 16; send 0x55 then 0xA3 back-to-back, no gap -> two valid pulses; data = 0x55 then 0xA3; byte_count = 2; frame_err never high; first valid 1+8+144 = 153 cycles after IDLE sees rx_s low.
- Low glitch of 5 cycles on idle line (CLKS_PER_BIT = 16) -> START aborts at its mid-sample; no valid, no frame_err; byte_count unchanged; busy high 8 cycles, then low.
- Frame 0x3C with stop bit driven 0, line then held low 100 cycles, then high, then good frame 0x81 -> one frame_err pulse; data stays at its previous value; no spurious START while low; then valid with data = 0x81.
- Assert reset for 1 cycle mid-DATA (bit 4 of 0xF0) -> next cycle: busy = 0, byte_count = 0, data = 0; the rest of the aborted frame produces no valid; the following clean 0x0F frame is received correctly.
- 256 good frames of 0x00..0xFF -> byte_count wraps to 0; every received byte equals the sent byte.
- CLKS_PER_BIT = 87 (default), send 0x48 at an effective 114000 baud (≈ −1%) -> valid, data = 0x48, no frame_err.
